// File: rtl/sseg_pkg.sv
// Shared constants for seven-segment encode/decode: segment patterns {a..g}
// (bit6=a, bit0=g) and the per-digit status codes.
package sseg_pkg;

    localparam logic [1:0] ST_BLANK   = 2'b00;
    localparam logic [1:0] ST_HEX     = 2'b01;
    localparam logic [1:0] ST_DASH    = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // Element i is the pattern that displays hex digit i.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,  // F E d C
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,  // b A 9 8
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,  // 7 6 5 4
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110   // 3 2 1 0
    };

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational decode of one 7-bit segment pattern into a status code and
// hex nibble; unrecognised patterns report invalid with nibble 0.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [1:0] o_status,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_status = ST_INVALID;
        o_nibble = 4'd0;
        if (i_seg == SEG_BLANK) begin
            o_status = ST_BLANK;
        end else if (i_seg == SEG_DASH) begin
            o_status = ST_DASH;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i_seg == SEG_HEX[i]) begin
                    o_status = ST_HEX;
                    o_nibble = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sseg_scan_reader.sv
// Reads back a multiplexed seven-segment bus: one sample per select slot after
// a settle window, per-digit debounce over consecutive scans, then classify.
module sseg_scan_reader
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SETTLE       = 2,
    parameter int STABLE_SCANS = 3
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET_N,
    input  logic [6:0]            i_SEG,
    input  logic [N_DIGITS-1:0]   i_DIG,
    output logic [4*N_DIGITS-1:0] o_VALUE,
    output logic [2*N_DIGITS-1:0] o_STATUS,
    output logic                  o_UPDATE,
    output logic                  o_SEL_ERR
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int CW = $clog2(STABLE_SCANS + 1);

    logic [N_DIGITS-1:0]          sel_q, sel_d;
    logic [SW-1:0]                settle_q, settle_d;
    logic                         sampled_q, sampled_d;
    logic [N_DIGITS-1:0][6:0]     cand_q, cand_d;
    logic [N_DIGITS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]        value_q, value_d;
    logic [2*N_DIGITS-1:0]        status_q, status_d;
    logic                         update_q, update_d;
    logic                         sel_err_q, sel_err_d;

    logic       slot_change, sample, multi_hot, accept;
    logic [1:0] dec_status;
    logic [3:0] dec_nibble;

    sseg_pattern_decode u_dec (
        .i_seg    (i_SEG),
        .o_status (dec_status),
        .o_nibble (dec_nibble)
    );

    assign slot_change = (i_DIG != sel_q);
    assign sample      = !slot_change && (settle_q == SW'(SETTLE)) && !sampled_q;
    assign multi_hot   = ((i_DIG & (i_DIG - N_DIGITS'(1))) != '0);

    always_comb begin
        sel_d     = sel_q;
        settle_d  = settle_q;
        sampled_d = sampled_q;
        if (slot_change) begin
            sel_d     = i_DIG;
            settle_d  = '0;
            sampled_d = 1'b0;
        end else begin
            if (settle_q != SW'(SETTLE)) settle_d = settle_q + SW'(1);
            if (sample) sampled_d = 1'b1;
        end
    end

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        status_d  = status_q;
        update_d  = 1'b0;
        sel_err_d = sample && multi_hot;
        accept    = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            accept = 1'b0;
            if (sample && !multi_hot && i_DIG[k]) begin
                if (i_SEG == cand_q[k]) begin
                    // Saturated count holds and never re-accepts.
                    if (cnt_q[k] != CW'(STABLE_SCANS)) begin
                        cnt_d[k] = cnt_q[k] + CW'(1);
                        accept   = (cnt_q[k] == CW'(STABLE_SCANS - 1));
                    end
                end else begin
                    cand_d[k] = i_SEG;
                    cnt_d[k]  = CW'(1);
                    accept    = (STABLE_SCANS == 1);
                end
                if (accept) begin
                    if ({dec_status, dec_nibble} != {status_q[2*k +: 2], value_q[4*k +: 4]})
                        update_d = 1'b1;
                    status_d[2*k +: 2] = dec_status;
                    value_d[4*k +: 4]  = dec_nibble;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            sel_q     <= '0;
            settle_q  <= '0;
            sampled_q <= 1'b0;
            cand_q    <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            status_q  <= '0;
            update_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            settle_q  <= settle_d;
            sampled_q <= sampled_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            status_q  <= status_d;
            update_q  <= update_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign o_VALUE   = value_q;
    assign o_STATUS  = status_q;
    assign o_UPDATE  = update_q;
    assign o_SEL_ERR = sel_err_q;

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed bench for sseg_scan_reader: table of scan phases plus hand-written
// select-error and mid-slot reset sequences.
module tb_sseg_scan_reader;

    logic        i_CLK = 1'b0;
    logic        i_RESET_N;
    logic [6:0]  i_SEG;
    logic [3:0]  i_DIG;
    logic [15:0] o_VALUE;
    logic [7:0]  o_STATUS;
    logic        o_UPDATE;
    logic        o_SEL_ERR;

    sseg_scan_reader #(.N_DIGITS(4), .SETTLE(2), .STABLE_SCANS(3)) dut (
        .i_CLK     (i_CLK),
        .i_RESET_N (i_RESET_N),
        .i_SEG     (i_SEG),
        .i_DIG     (i_DIG),
        .o_VALUE   (o_VALUE),
        .o_STATUS  (o_STATUS),
        .o_UPDATE  (o_UPDATE),
        .o_SEL_ERR (o_SEL_ERR)
    );

    always #5 i_CLK = ~i_CLK;

    localparam logic [6:0] P_1    = 7'b0110000;
    localparam logic [6:0] P_2    = 7'b1101101;
    localparam logic [6:0] P_8    = 7'b1111111;
    localparam logic [6:0] P_A    = 7'b1110111;
    localparam logic [6:0] P_B    = 7'b0011111;
    localparam logic [6:0] P_DASH = 7'b0000001;
    localparam logic [6:0] P_BAD  = 7'b1010101;

    int n_chk  = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    always @(negedge i_CLK) begin
        if (o_UPDATE)  upd_cnt++;
        if (o_SEL_ERR) err_cnt++;
    end

    typedef struct {
        logic            rst;
        logic [3:0][6:0] segs;
        int              garb;
        int              scans;
        logic [15:0]     exp_val;
        logic [7:0]      exp_st;
        int              exp_upd;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [3:0][6:0] mk(input logic [6:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_slot(input logic [3:0] dig, input logic [6:0] seg, input int garb);
        for (int c = 0; c < 8; c++) begin
            i_DIG = dig;
            i_SEG = (c < garb) ? P_8 : seg;
            @(posedge i_CLK); #1;
        end
    endtask

    task automatic do_scan(input logic [3:0][6:0] segs, input int garb);
        for (int d = 0; d < 4; d++) do_slot(4'(1 << d), segs[d], garb);
    endtask

    task automatic do_reset();
        i_RESET_N = 1'b0;
        i_DIG = '0;
        i_SEG = '0;
        repeat (2) @(posedge i_CLK);
        #1;
        chk("rst_value",   32'(o_VALUE),   32'h0);
        chk("rst_status",  32'(o_STATUS),  32'h0);
        chk("rst_update",  32'(o_UPDATE),  32'h0);
        chk("rst_sel_err", 32'(o_SEL_ERR), 32'h0);
        i_RESET_N = 1'b1;
        @(posedge i_CLK); #1;
    endtask

    initial begin
        logic [7:0] mask;
        int u0, e0;
        i_RESET_N = 1'b0;
        i_DIG = '0;
        i_SEG = '0;

        tbl[0] = '{1'b1, mk(P_B, P_A, P_2, P_1),    0, 2, 16'h0000, 8'h00, 0};
        tbl[1] = '{1'b0, mk(P_B, P_A, P_2, P_1),    0, 1, 16'h12AB, 8'h55, 4};
        tbl[2] = '{1'b1, mk(P_B, P_A, P_2, P_1),    2, 2, 16'h0000, 8'h00, 0};
        tbl[3] = '{1'b0, mk(P_B, P_A, P_2, P_1),    2, 1, 16'h12AB, 8'h55, 4};
        tbl[4] = '{1'b0, mk(P_8, P_A, P_2, P_1),    0, 1, 16'h12AB, 8'h55, 0};
        tbl[5] = '{1'b0, mk(P_B, P_A, P_2, P_1),    0, 1, 16'h12AB, 8'h55, 0};
        tbl[6] = '{1'b0, mk(P_8, P_A, P_2, P_1),    0, 3, 16'h12A8, 8'h55, 1};
        tbl[7] = '{1'b0, mk(P_8, P_A, P_DASH, P_1), 0, 3, 16'h10A8, 8'h65, 1};
        tbl[8] = '{1'b0, mk(P_8, P_A, P_DASH, P_BAD), 0, 3, 16'h00A8, 8'hE5, 1};

        for (int r = 0; r < 9; r++) begin
            if (tbl[r].rst) do_reset();
            u0 = upd_cnt;
            for (int s = 0; s < tbl[r].scans; s++) do_scan(tbl[r].segs, tbl[r].garb);
            chk($sformatf("row%0d_value", r),  32'(o_VALUE),     32'(tbl[r].exp_val));
            chk($sformatf("row%0d_status", r), 32'(o_STATUS),    32'(tbl[r].exp_st));
            chk($sformatf("row%0d_updates", r), 32'(upd_cnt - u0), 32'(tbl[r].exp_upd));
        end

        // Multi-hot select: one error pulse on the sample edge, nothing updated.
        u0 = upd_cnt;
        e0 = err_cnt;
        mask = '0;
        for (int c = 0; c < 8; c++) begin
            i_DIG = 4'b0011;
            i_SEG = P_1;
            @(posedge i_CLK); #1;
            mask[c] = o_SEL_ERR;
        end
        chk("selerr_mask",   32'(mask),            32'h08);
        chk("selerr_count",  32'(err_cnt - e0),    32'd1);
        chk("selerr_value",  32'(o_VALUE),         32'h00A8);
        chk("selerr_status", 32'(o_STATUS),        32'hE5);

        // Zero-hot select: no action at all.
        e0 = err_cnt;
        for (int c = 0; c < 8; c++) begin
            i_DIG = 4'b0000;
            i_SEG = P_2;
            @(posedge i_CLK); #1;
        end
        chk("zero_selerr",  32'(err_cnt - e0), 32'd0);
        chk("zero_updates", 32'(upd_cnt - u0), 32'd0);
        chk("zero_value",   32'(o_VALUE),      32'h00A8);

        // Async reset in the middle of a slot, then re-lock from scratch.
        i_DIG = 4'b0010;
        i_SEG = P_A;
        repeat (3) @(posedge i_CLK);
        #3 i_RESET_N = 1'b0;
        #1;
        chk("async_value",  32'(o_VALUE),  32'h0);
        chk("async_status", 32'(o_STATUS), 32'h0);
        i_DIG = '0;
        repeat (2) @(posedge i_CLK);
        #1 i_RESET_N = 1'b1;
        u0 = upd_cnt;
        do_scan(mk(P_B, P_A, P_2, P_1), 0);
        do_scan(mk(P_B, P_A, P_2, P_1), 0);
        chk("relock2_value", 32'(o_VALUE), 32'h0);
        do_scan(mk(P_B, P_A, P_2, P_1), 0);
        chk("relock3_value",   32'(o_VALUE),      32'h12AB);
        chk("relock3_status",  32'(o_STATUS),     32'h55);
        chk("relock3_updates", 32'(upd_cnt - u0), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
